// File: rtl/uart_pkg.sv
// Shared definitions for the UART debug printers: ASCII constants, the nibble
// to hex-digit mapping and the state encoding of uart_hex_fmt.
package uart_pkg;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_X  = 8'h78;
    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    localparam logic [2:0] HF_IDLE = 3'd0;
    localparam logic [2:0] HF_P0   = 3'd1;
    localparam logic [2:0] HF_P1   = 3'd2;
    localparam logic [2:0] HF_DIG  = 3'd3;
    localparam logic [2:0] HF_CR   = 3'd4;
    localparam logic [2:0] HF_LF   = 3'd5;

    // Uppercase hex digit for one nibble.
    function automatic logic [7:0] hex_to_ascii(input logic [3:0] nibble);
        if (nibble < 4'd10) begin
            return ASCII_0 + {4'h0, nibble};
        end
        return ASCII_A + {4'h0, nibble} - 8'd10;
    endfunction

endpackage

// File: rtl/uart_hex_fmt.sv
// Formats a latched binary word as an ASCII hex line ("0x" digits CR LF) and
// pushes it byte by byte into uart_dbg through its wr/msg/full interface.
module uart_hex_fmt
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PREFIX     = 1,
    parameter int NEWLINE    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] value,
    output logic                  busy,
    output logic                  wr,
    output logic [7:0]            msg,
    input  logic                  full
);

    localparam int NDIG  = DATA_WIDTH / 4;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    if (((DATA_WIDTH % 4) != 0) || (DATA_WIDTH < 4)) begin : g_bad_width
        $error("uart_hex_fmt: DATA_WIDTH must be a multiple of 4 and at least 4");
    end

    logic [2:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [3:0]            nibble;

    assign busy   = (state_q != HF_IDLE);
    assign wr     = busy && !full;
    assign nibble = shadow_q[{cnt_q, 2'b00} +: 4];

    always_comb begin
        msg = 8'h00;
        case (state_q)
            HF_P0:   msg = ASCII_0;
            HF_P1:   msg = ASCII_X;
            HF_DIG:  msg = hex_to_ascii(nibble);
            HF_CR:   msg = ASCII_CR;
            HF_LF:   msg = ASCII_LF;
            default: msg = 8'h00;
        endcase
    end

    // Outside IDLE the FSM only moves on a byte that uart_dbg actually took.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        if (state_q == HF_IDLE) begin
            if (start) begin
                shadow_d = value;
                cnt_d    = CNT_W'(NDIG - 1);
                state_d  = (PREFIX != 0) ? HF_P0 : HF_DIG;
            end
        end else if (wr) begin
            case (state_q)
                HF_P0:  state_d = HF_P1;
                HF_P1:  state_d = HF_DIG;
                HF_DIG: begin
                    if (cnt_q == '0) begin
                        state_d = (NEWLINE != 0) ? HF_CR : HF_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                HF_CR:   state_d = HF_LF;
                default: state_d = HF_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= HF_IDLE;
            shadow_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
